tomasulo_cdb_arb: RTL and testbench
===================================

Name: tomasulo_cdb_arb

Overview:
- Arbitrates the Common Data Bus (CDB) between REQ_N functional-unit writeback ports: arith, logic and mpy by default.
- Each requester has a one-entry holding slot with valid/ready backpressure.
- A round-robin arbiter picks one slot per cycle and drives a registered cdb_t broadcast (vld, tag, wdata) to reservation stations and the register file.
- Sits between the execution pipes and the RS/regfile tag-match logic.

Parameters:
- REQ_N, 3, number of requesters (index 0 = arith, 1 = logic, 2 = mpy).
- TAG_W, 5, tag width; matches tag_t.
- WORD_W, 32, data width; matches word_t.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_vld_i  in  REQ_N  per-requester result valid.
- req_tag_i  in  REQ_N*TAG_W  per-requester tag; requester i occupies bits [i*TAG_W +: TAG_W].
- req_wdata_i  in  REQ_N*WORD_W  per-requester result; requester i occupies bits [i*WORD_W +: WORD_W].
- req_rdy_o  out  REQ_N  slot can accept this cycle.
- cdb_vld_o  out  1  CDB broadcast valid (registered).
- cdb_tag_o  out  TAG_W  CDB tag (registered).
- cdb_wdata_o  out  WORD_W  CDB data (registered).
- cdb_src_o  out  REQ_N  one-hot source of the current broadcast (registered); zero when cdb_vld_o=0.
- pend_o  out  REQ_N  holding-slot occupancy (registered).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all slots invalid; pend_o=0; cdb_vld_o=0; cdb_src_o=0; cdb_tag_o=0; cdb_wdata_o=0.
  - RR pointer=0, so requester 0 has highest priority.
  - req_rdy_o=all ones, combinationally derived from empty slots.
- Reset mid-operation: held results are discarded. No broadcast is produced for them. Upstream re-issue is not this block's concern.
- Acceptance:
  - req_rdy_o[i] = !slot_vld[i] | gnt[i]. A slot drains and refills in the same cycle.
  - Transfer occurs when req_vld_i[i] & req_rdy_o[i]; tag and wdata are captured into slot i at the edge.
  - req_vld_i[i] while rdy=0: the block does not sample. The requester holds its data stable until accepted.
- Arbitration (combinational, each cycle, over slot_vld):
  - Round-robin search starts at index ptr, wrapping modulo REQ_N. First valid slot wins. gnt is one-hot or zero.
  - On a grant to index k, ptr <= (k+1) mod REQ_N. With no grant, ptr holds.
- Broadcast register, updated every edge:
  - cdb_vld_o <= |gnt; cdb_tag_o/cdb_wdata_o <= granted slot contents; cdb_src_o <= gnt.
  - When |gnt=0: cdb_vld_o=0, cdb_src_o=0; tag/wdata hold their previous value.
- Latency: accept at edge E; slot valid in the cycle after E; earliest cdb_vld_o=1 in the cycle after edge E+1. Minimum 2 edges, accept to broadcast.
- Throughput: one broadcast per cycle sustained. With all slots full and requesters streaming, every requester is served once per REQ_N cycles.
- Starvation: a valid slot waits at most REQ_N-1 grants.
- Simultaneous events:
  - A slot granted and refilled in the same cycle broadcasts the old contents; the new contents are arbitrated next cycle.
  - All requests arriving in one cycle are broadcast in order ptr, ptr+1, ...
- No tag checking: duplicate tags are broadcast as presented.

Optional Feature:
- Macro: TOMASULO_CDB_ARB_MPY_PRIO_EN.
- Defined:
  - slot REQ_N-1 (mpy) has absolute priority whenever valid. The long-latency pipe is never stalled by CDB contention.
  - Remaining slots are round-robin among indices 0..REQ_N-2. ptr advances only on grants to those slots.
  - Starvation bound for the others is not guaranteed.
- Undefined: pure round-robin as above.

Test Plan:
- Reset then single request: req 1 tag=5'h07 wdata=32'hDEAD_BEEF at edge 1 -> cdb_vld_o=1, tag=07, wdata=DEADBEEF, cdb_src_o=3'b010 after edge 2; cdb_vld_o=0 after edge 3.
- All three requesters valid in the same cycle, tags 1/2/3 -> broadcasts tags 1,2,3 on three consecutive cycles; req_rdy_o deasserts only for slots not yet granted.
- Continuous streaming on all requesters for 30 cycles -> cdb_vld_o=1 every cycle after fill; src order 0,1,2 repeating; no tag lost or duplicated (scoreboard).
- Backpressure: req 0 streaming while req 2 holds a value -> req_rdy_o[0]=0 in the cycle its slot is full and not granted; data held stable upstream is captured exactly once.
- Assert rst_n low while slots 0 and 2 are full -> pend_o=0 and cdb_vld_o=0 immediately (async); no broadcast of the held tags after release.
- With TOMASULO_CDB_ARB_MPY_PRIO_EN, req 2 streaming plus req 0 pending -> req 2 granted every cycle; req 0 is granted only on cycles where slot 2 is empty. Without the macro, the grants alternate.

Source files
------------

// File: rtl/tomasulo_cdb_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tomasulo_cdb_arb
//  Description : Common Data Bus arbiter. One holding slot per functional-unit
//                writeback port with valid/ready backpressure. A round-robin
//                arbiter picks one slot per cycle and drives a registered
//                broadcast (vld, tag, wdata, one-hot source).
//  Option      : TOMASULO_CDB_ARB_MPY_PRIO_EN - when defined, slot REQ_N-1
//                (mpy) wins whenever it is valid. The remaining slots share
//                round-robin priority among themselves.
//  Revision    : 1.0 - initial release
// ============================================================================
module tomasulo_cdb_arb #(
   parameter int REQ_N  = 3,
   parameter int TAG_W  = 5,
   parameter int WORD_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [REQ_N-1:0]        req_vld_i,
   input  logic [REQ_N*TAG_W-1:0]  req_tag_i,
   input  logic [REQ_N*WORD_W-1:0] req_wdata_i,
   output logic [REQ_N-1:0]        req_rdy_o,
   output logic                    cdb_vld_o,
   output logic [TAG_W-1:0]        cdb_tag_o,
   output logic [WORD_W-1:0]       cdb_wdata_o,
   output logic [REQ_N-1:0]        cdb_src_o,
   output logic [REQ_N-1:0]        pend_o
);

   localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;
`ifdef TOMASULO_CDB_ARB_MPY_PRIO_EN
   // The mpy slot sits outside the rotation; only the others rotate.
   localparam int RR_N = REQ_N - 1;
`else
   localparam int RR_N = REQ_N;
`endif

   logic [REQ_N-1:0]             r_slot_vld;
   logic [REQ_N-1:0][TAG_W-1:0]  r_slot_tag;
   logic [REQ_N-1:0][WORD_W-1:0] r_slot_wdata;
   logic [PTR_W-1:0]             r_ptr;

   logic [REQ_N-1:0]  w_gnt;
   logic              w_found;
   logic              w_ptr_adv;
   logic [PTR_W-1:0]  w_nxt_ptr;
   logic [TAG_W-1:0]  w_btag;
   logic [WORD_W-1:0] w_bdata;

   // Round-robin search: first pass covers ptr..RR_N-1, second pass wraps to 0..ptr-1.
   always_comb begin
      w_gnt     = '0;
      w_found   = 1'b0;
      w_nxt_ptr = r_ptr;
      for (int i = 0; i < RR_N; i++) begin
         if (!w_found && (PTR_W'(i) >= r_ptr) && r_slot_vld[i]) begin
            w_gnt[i]  = 1'b1;
            w_found   = 1'b1;
            w_nxt_ptr = (i + 1 == RR_N) ? '0 : PTR_W'(i + 1);
         end
      end
      for (int i = 0; i < RR_N; i++) begin
         if (!w_found && (PTR_W'(i) < r_ptr) && r_slot_vld[i]) begin
            w_gnt[i]  = 1'b1;
            w_found   = 1'b1;
            w_nxt_ptr = (i + 1 == RR_N) ? '0 : PTR_W'(i + 1);
         end
      end
      w_ptr_adv = w_found;
`ifdef TOMASULO_CDB_ARB_MPY_PRIO_EN
      // Mpy overrides the rotation and leaves the pointer untouched.
      if (r_slot_vld[REQ_N-1]) begin
         w_gnt            = '0;
         w_gnt[REQ_N-1]   = 1'b1;
         w_ptr_adv        = 1'b0;
      end
`endif
   end

   // One-hot grant selects the broadcast payload with an AND-OR mux.
   always_comb begin
      w_btag  = '0;
      w_bdata = '0;
      for (int i = 0; i < REQ_N; i++) begin
         if (w_gnt[i]) begin
            w_btag  = w_btag  | r_slot_tag[i];
            w_bdata = w_bdata | r_slot_wdata[i];
         end
      end
   end

   // A slot being drained this cycle can take a new result at the same edge.
   assign req_rdy_o = ~r_slot_vld | w_gnt;
   assign pend_o    = r_slot_vld;

   generate
      for (genvar g = 0; g < REQ_N; g++) begin : g_slot
         // Holding slot: capture on handshake, otherwise release when granted.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_slot_vld[g]   <= 1'b0;
               r_slot_tag[g]   <= '0;
               r_slot_wdata[g] <= '0;
            end else if (req_vld_i[g] && req_rdy_o[g]) begin
               r_slot_vld[g]   <= 1'b1;
               r_slot_tag[g]   <= req_tag_i[g*TAG_W +: TAG_W];
               r_slot_wdata[g] <= req_wdata_i[g*WORD_W +: WORD_W];
            end else if (w_gnt[g]) begin
               r_slot_vld[g]   <= 1'b0;
            end
         end
      end
   endgenerate

   // Rotation pointer moves one past the round-robin winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_ptr_adv) begin
         r_ptr <= w_nxt_ptr;
      end
   end

   // Broadcast register; payload holds when nothing is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cdb_vld_o   <= 1'b0;
         cdb_src_o   <= '0;
         cdb_tag_o   <= '0;
         cdb_wdata_o <= '0;
      end else begin
         cdb_vld_o <= |w_gnt;
         cdb_src_o <= w_gnt;
         if (|w_gnt) begin
            cdb_tag_o   <= w_btag;
            cdb_wdata_o <= w_bdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tomasulo_cdb_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_tomasulo_cdb_arb
//  Description : Scoreboard bench for tomasulo_cdb_arb. The driver advances a
//                behavioural model each cycle and queues the expected
//                broadcast; a monitor pops and compares one entry per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tomasulo_cdb_arb;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req_vld_i;
   logic [14:0] req_tag_i;
   logic [95:0] req_wdata_i;
   logic [2:0]  req_rdy_o;
   logic        cdb_vld_o;
   logic [4:0]  cdb_tag_o;
   logic [31:0] cdb_wdata_o;
   logic [2:0]  cdb_src_o;
   logic [2:0]  pend_o;

   tomasulo_cdb_arb #(.REQ_N(3), .TAG_W(5), .WORD_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_vld_i   (req_vld_i),
      .req_tag_i   (req_tag_i),
      .req_wdata_i (req_wdata_i),
      .req_rdy_o   (req_rdy_o),
      .cdb_vld_o   (cdb_vld_o),
      .cdb_tag_o   (cdb_tag_o),
      .cdb_wdata_o (cdb_wdata_o),
      .cdb_src_o   (cdb_src_o),
      .pend_o      (pend_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          vld;
      logic [4:0]  tag;
      logic [31:0] data;
      logic [2:0]  src;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Requester side: a presented result stays put until accepted.
   logic [2:0]  pres;
   logic [4:0]  ptag  [3];
   logic [31:0] pdata [3];
   logic [4:0]  tag_ctr;

   // Reference model: slot contents as plain arrays plus a rotation index.
   bit          m_vld  [3];
   logic [4:0]  m_tag  [3];
   logic [31:0] m_data [3];
   int          m_ptr;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [2:0] m_pend();
      return {m_vld[2], m_vld[1], m_vld[0]};
   endfunction

   task automatic issue(input int i, input logic [4:0] t, input logic [31:0] d);
      pres[i]  = 1'b1;
      ptag[i]  = t;
      pdata[i] = d;
   endtask

   task automatic issue_auto(input int i);
      tag_ctr = tag_ctr + 5'd1;
      issue(i, tag_ctr, $urandom);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin
         m_vld[i] = 0;
         m_tag[i] = '0;
         m_data[i] = '0;
      end
      m_ptr = 0;
      pres  = '0;
   endtask

   // One clock: drive at the falling edge, check handshake outputs, predict the next edge.
   task automatic step();
      int       g;
      bit [2:0] er;
      exp_t     e;
      @(negedge clk);
      req_vld_i   = pres;
      req_tag_i   = {ptag[2], ptag[1], ptag[0]};
      req_wdata_i = {pdata[2], pdata[1], pdata[0]};
      #1;
      g = -1;
`ifdef TOMASULO_CDB_ARB_MPY_PRIO_EN
      if (m_vld[2]) g = 2;
      else
         for (int k = 0; k < 2; k++) begin
            int j = (m_ptr + k) % 2;
            if (g < 0 && m_vld[j]) g = j;
         end
`else
      for (int k = 0; k < 3; k++) begin
         int j = (m_ptr + k) % 3;
         if (g < 0 && m_vld[j]) g = j;
      end
`endif
      for (int i = 0; i < 3; i++) er[i] = !m_vld[i] || (g == i);
      chk("req_rdy", 64'(req_rdy_o), 64'(er));
      chk("pend", 64'(pend_o), 64'(m_pend()));
      e.vld  = (g >= 0);
      e.src  = (g >= 0) ? 3'(1 << g) : 3'b000;
      e.tag  = (g >= 0) ? m_tag[g]  : 5'd0;
      e.data = (g >= 0) ? m_data[g] : 32'd0;
      sb.push_back(e);
`ifdef TOMASULO_CDB_ARB_MPY_PRIO_EN
      if (g >= 0 && g < 2) m_ptr = (g + 1) % 2;
`else
      if (g >= 0) m_ptr = (g + 1) % 3;
`endif
      for (int i = 0; i < 3; i++) begin
         if (pres[i] && er[i]) begin
            m_vld[i]  = 1;
            m_tag[i]  = ptag[i];
            m_data[i] = pdata[i];
            pres[i]   = 1'b0;
         end else if (g == i) begin
            m_vld[i] = 0;
         end
      end
   endtask

   // Monitor: every cycle's registered broadcast is matched against the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && sb.size() > 0) begin
         e = sb.pop_front();
         chk("cdb_vld", 64'(cdb_vld_o), 64'(e.vld));
         chk("cdb_src", 64'(cdb_src_o), 64'(e.src));
         if (e.vld) begin
            chk("cdb_tag", 64'(cdb_tag_o), 64'(e.tag));
            chk("cdb_wdata", 64'(cdb_wdata_o), 64'(e.data));
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      req_vld_i   = '0;
      req_tag_i   = '0;
      req_wdata_i = '0;
      tag_ctr     = '0;
      for (int i = 0; i < 3; i++) begin
         ptag[i]  = '0;
         pdata[i] = '0;
      end
      model_clear();
      #1;
      chk("rst_pend", 64'(pend_o), 64'(0));
      chk("rst_vld", 64'(cdb_vld_o), 64'(0));
      chk("rst_src", 64'(cdb_src_o), 64'(0));
      chk("rst_tag", 64'(cdb_tag_o), 64'(0));
      chk("rst_wdata", 64'(cdb_wdata_o), 64'(0));
      chk("rst_rdy", 64'(req_rdy_o), 64'(3'b111));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single request on the logic port.
      issue(1, 5'h07, 32'hDEAD_BEEF);
      repeat (4) step();

      // All three in one cycle, tags 1/2/3.
      issue(0, 5'd1, 32'h1111_0001);
      issue(1, 5'd2, 32'h2222_0002);
      issue(2, 5'd3, 32'h3333_0003);
      repeat (5) step();

      // Continuous streaming on every port.
      for (int c = 0; c < 30; c++) begin
         for (int i = 0; i < 3; i++) if (!pres[i]) issue_auto(i);
         step();
      end
      repeat (4) step();

      // Backpressure: port 0 streams while port 2 holds one value.
      issue_auto(2);
      for (int c = 0; c < 12; c++) begin
         if (!pres[0]) issue_auto(0);
         step();
      end
      repeat (4) step();

      // Mpy streaming with arith pending.
      issue_auto(0);
      for (int c = 0; c < 8; c++) begin
         if (!pres[2]) issue_auto(2);
         step();
      end
      repeat (5) step();

      // Reset while slots 0 and 2 hold results.
      issue(0, 5'h0A, 32'hAAAA_000A);
      issue(2, 5'h0C, 32'hCCCC_000C);
      step();
      @(negedge clk);
      req_vld_i = '0;
      chk("pend_pre_rst", 64'(pend_o), 64'(m_pend()));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pend", 64'(pend_o), 64'(0));
      chk("arst_vld", 64'(cdb_vld_o), 64'(0));
      chk("arst_src", 64'(cdb_src_o), 64'(0));
      chk("arst_rdy", 64'(req_rdy_o), 64'(3'b111));
      sb.delete();
      model_clear();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) step();

      // Randomised traffic.
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < 3; i++)
            if (!pres[i] && ($urandom_range(0, 1) == 1)) issue_auto(i);
         step();
      end
      repeat (6) step();

      @(negedge clk);
      #2;
      chk("sb_drain", 64'(sb.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
